sipo_deser: RTL and testbench

- Serial-in, parallel-out receiver.
- Assembles a WIDTH-bit word from a qualified serial bit stream and presents it on a held parallel output with a valid/ready handshake.
- It is the receiving end for the team's parallel shift registers driven as serializers.
- It sits between a serial link front-end and word-wide datapath logic.

---
 rtl/sipo_deser_pkg.sv | 12 +
 rtl/sipo_deser_if.sv | 27 ++
 rtl/sipo_out_reg.sv | 47 ++++
 rtl/sipo_deser.sv | 115 +++++++++++
 tb/tb_sipo_deser.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sipo_deser_pkg.sv
// Shared encodings for the serial-in parallel-out receiver.
package sipo_deser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic ORDER_MSB = 1'b1;
  localparam logic ORDER_LSB = 1'b0;

endpackage

// File: rtl/sipo_deser_if.sv
// Serial-side inputs and word-side handshake of the SIPO receiver.
interface sipo_deser_if #(
  parameter int WIDTH = 16
);

  logic             serial_in;
  logic             bit_valid;
  logic             frame_start;
  logic             msb_first;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic             overrun;
  logic             clr_overrun;

  modport master (
    output serial_in, bit_valid, frame_start, msb_first, data_ready, clr_overrun,
    input  data_out, data_valid, busy, overrun
  );

  modport slave (
    input  serial_in, bit_valid, frame_start, msb_first, data_ready, clr_overrun,
    output data_out, data_valid, busy, overrun
  );

endinterface

// File: rtl/sipo_out_reg.sv
// Held output word with valid/ready; accepts a load when empty or draining on the same edge.
module sipo_out_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             full
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             take;

  assign take = data_valid_q && data_ready;
  // full means a load on this edge would have nowhere to go
  assign full = data_valid_q && !data_ready;

  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    if (load && !full) begin
      data_out_d   = word;
      data_valid_d = 1'b1;
    end else if (take) begin
      data_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out receiver: assembles WIDTH bits per frame and presents the word
// on the completing edge; a word completing against a stalled consumer is dropped and flagged.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  sipo_deser_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             order_q, order_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt_cur;
  logic             order_cur;
  logic             beat;
  logic             load;
  logic             full;
  logic [WIDTH-1:0] out_dat;
  logic             out_vld;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sreg_d    = sreg_q;
    order_d   = order_q;
    load      = 1'b0;
    base      = sreg_q;
    order_cur = order_q;
    cnt_cur   = count_q;

    // A start beat restarts the frame from scratch, discarding any partial word
    if (bus.frame_start) begin
      base      = '0;
      order_cur = bus.msb_first;
      cnt_cur   = '0;
    end

    if (order_cur == ORDER_MSB) begin
      shifted = {base[WIDTH-2:0], bus.serial_in};
    end else begin
      shifted = {bus.serial_in, base[WIDTH-1:1]};
    end

    beat = bus.bit_valid && (bus.frame_start || (state_q == ST_SHIFT));

    if (beat) begin
      sreg_d  = shifted;
      order_d = order_cur;
      if (cnt_cur == LAST) begin
        load    = 1'b1;
        state_d = ST_IDLE;
        count_d = '0;
      end else begin
        state_d = ST_SHIFT;
        count_d = cnt_cur + CNT_W'(1);
      end
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (load && full) begin
      overrun_d = 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      sreg_q    <= '0;
      order_q   <= ORDER_MSB;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sreg_q    <= sreg_d;
      order_q   <= order_d;
      overrun_q <= overrun_d;
    end
  end

  // The completing beat's shifted value already holds all WIDTH bits
  sipo_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .word       (shifted),
    .data_ready (bus.data_ready),
    .data_out   (out_dat),
    .data_valid (out_vld),
    .full       (full)
  );

  assign bus.data_out   = out_dat;
  assign bus.data_valid = out_vld;
  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: vector table plus hand-written corner sequences.
module tb_sipo_deser;

  logic clk;
  logic reset;

  sipo_deser_if #(.WIDTH(16)) bus ();

  sipo_deser #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [15:0] pat;
    logic        msb_flag;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_cycle();
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic start, input logic msb);
    bus.serial_in   = b;
    bus.bit_valid   = 1'b1;
    bus.frame_start = start;
    bus.msb_first   = msb;
    @(posedge clk);
    #1;
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  // Stream is always pat[15] first; msb_flag tells the DUT how to interpret it.
  task automatic send_stream(input logic [15:0] pat, input logic msb_flag);
    for (int i = 0; i < 16; i++) send_bit(pat[15-i], (i == 0), msb_flag);
  endtask

  initial begin
    logic [15:0] w;

    vecs[0] = '{16'hA5C3, 1'b1, 16'hA5C3};
    vecs[1] = '{16'h1234, 1'b0, 16'h2C48};
    vecs[2] = '{16'h8000, 1'b0, 16'h0001};
    vecs[3] = '{16'h00FF, 1'b0, 16'hFF00};
    vecs[4] = '{16'hBEEF, 1'b1, 16'hBEEF};
    vecs[5] = '{16'hF0A5, 1'b0, 16'hA50F};

    reset           = 1'b1;
    bus.serial_in   = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.msb_first   = 1'b1;
    bus.data_ready  = 1'b1;
    bus.clr_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    check("rst_valid", 32'(bus.data_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    reset = 1'b0;
    idle_cycle();

    // bit_valid without frame_start in IDLE does nothing
    send_bit(1'b1, 1'b0, 1'b1);
    check("idle_ignore_busy", 32'(bus.busy), 32'h0);

    // Table: full frames with data_ready=1; valid for exactly one cycle
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++) begin
        send_bit(vecs[v].pat[15-i], (i == 0), vecs[v].msb_flag);
        if (i == 7) check($sformatf("v%0d_busy_mid", v), 32'(bus.busy), 32'h1);
      end
      check($sformatf("v%0d_data", v), 32'(bus.data_out), 32'(vecs[v].exp));
      check($sformatf("v%0d_valid", v), 32'(bus.data_valid), 32'h1);
      check($sformatf("v%0d_busy_end", v), 32'(bus.busy), 32'h0);
      idle_cycle();
      check($sformatf("v%0d_valid_drop", v), 32'(bus.data_valid), 32'h0);
    end

    // LSB first with a 3-cycle gap between bits 7 and 8
    w = 16'h1234;
    for (int i = 0; i < 8; i++) send_bit(w[i], (i == 0), 1'b0);
    for (int g = 0; g < 3; g++) begin
      idle_cycle();
      check("gap_busy", 32'(bus.busy), 32'h1);
    end
    for (int i = 8; i < 16; i++) send_bit(w[i], 1'b0, 1'b0);
    check("gap_data", 32'(bus.data_out), 32'h1234);
    check("gap_valid", 32'(bus.data_valid), 32'h1);
    idle_cycle();

    // Backpressure: second word dropped, overrun sticky until cleared
    bus.data_ready = 1'b0;
    send_stream(16'h00FF, 1'b1);
    check("bp_first_data", 32'(bus.data_out), 32'h00FF);
    check("bp_first_ovr", 32'(bus.overrun), 32'h0);
    send_stream(16'hFFFF, 1'b1);
    check("bp_held_data", 32'(bus.data_out), 32'h00FF);
    check("bp_held_valid", 32'(bus.data_valid), 32'h1);
    check("bp_ovr_set", 32'(bus.overrun), 32'h1);
    bus.data_ready = 1'b1;
    idle_cycle();
    check("bp_xfer_valid", 32'(bus.data_valid), 32'h0);
    check("bp_ovr_sticky", 32'(bus.overrun), 32'h1);
    idle_cycle();
    check("bp_ovr_still", 32'(bus.overrun), 32'h1);
    bus.clr_overrun = 1'b1;
    idle_cycle();
    bus.clr_overrun = 1'b0;
    check("bp_ovr_clr", 32'(bus.overrun), 32'h0);

    // Handshake on the same edge the next word completes
    bus.data_ready = 1'b0;
    send_stream(16'h1111, 1'b1);
    w = 16'h8001;
    for (int i = 0; i < 15; i++) send_bit(w[15-i], (i == 0), 1'b1);
    check("sim_hold_data", 32'(bus.data_out), 32'h1111);
    bus.data_ready = 1'b1;
    send_bit(w[0], 1'b0, 1'b1);
    check("sim_data", 32'(bus.data_out), 32'h8001);
    check("sim_valid", 32'(bus.data_valid), 32'h1);
    check("sim_ovr", 32'(bus.overrun), 32'h0);
    idle_cycle();
    check("sim_drain", 32'(bus.data_valid), 32'h0);

    // Frame restart after 5 bits
    w = 16'h7777;
    for (int i = 0; i < 5; i++) send_bit(w[15-i], (i == 0), 1'b0);
    send_stream(16'hBEEF, 1'b1);
    check("rs_data", 32'(bus.data_out), 32'hBEEF);
    check("rs_valid", 32'(bus.data_valid), 32'h1);
    check("rs_ovr", 32'(bus.overrun), 32'h0);
    idle_cycle();

    // Async reset mid-frame with a held word
    bus.data_ready = 1'b0;
    send_stream(16'h3C3C, 1'b1);
    w = 16'h5A5A;
    for (int i = 0; i < 9; i++) send_bit(w[15-i], (i == 0), 1'b1);
    check("ar_pre_busy", 32'(bus.busy), 32'h1);
    check("ar_pre_valid", 32'(bus.data_valid), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ar_data", 32'(bus.data_out), 32'h0);
    check("ar_valid", 32'(bus.data_valid), 32'h0);
    check("ar_busy", 32'(bus.busy), 32'h0);
    check("ar_ovr", 32'(bus.overrun), 32'h0);
    #1;
    reset = 1'b0;
    bus.data_ready = 1'b1;
    idle_cycle();
    // Remaining bits of the killed frame must not start anything
    for (int i = 9; i < 16; i++) send_bit(w[15-i], 1'b0, 1'b1);
    check("ar_stale_busy", 32'(bus.busy), 32'h0);
    check("ar_stale_valid", 32'(bus.data_valid), 32'h0);
    send_stream(16'h5A5A, 1'b1);
    check("ar_next_data", 32'(bus.data_out), 32'h5A5A);
    check("ar_next_valid", 32'(bus.data_valid), 32'h1);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
